// File: rtl/adc_control_conditioner.sv
// adc_control_conditioner: turns raw ADC frames into clean control values.
// The frame strobe is synchronised into i_clock and the frequency word is
// smoothed by an EMA. A hysteresis gate stops small pitch jitter from
// reaching o_frequency. The harmonic scale is taken from the top bits of
// i_data1. A stale flag rises when frames stop arriving.
module adc_control_conditioner #(
  parameter int unsigned SMOOTH_SHIFT   = 3,
  parameter logic [15:0] HYSTERESIS     = 16'd4,
  parameter int unsigned SCALE_SHIFT    = 11,
  parameter logic [15:0] RESET_FREQ     = 16'd1000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd7200000
) (
  input  logic        i_clock,
  input  logic        i_rstn,
  input  logic        i_data_received,
  input  logic [15:0] i_data0,
  input  logic [15:0] i_data1,
  output logic [15:0] o_frequency,
  output logic [5:0]  o_harmonic_scale,
  output logic        o_update,
  output logic        o_stale
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = DW + SMOOTH_SHIFT;
  localparam int unsigned CW = 24;
  localparam int unsigned SW = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER  = 2'd1,
    COMPARE = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  state_t          state_q;
  logic            s1_q, s2_q, s3_q;
  logic            event_c;
  logic            pending_q;
  logic            primed_q;
  logic            published_q;
  logic [DW-1:0]   samp_q;
  logic [DW-1:0]   raw_scale_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [AW-1:0]   acc_next_c;
  logic [DW-1:0]   filt_c;
  logic [DW:0]     diff_c;
  logic            freq_load_c;
  logic            freq_chg_c;
  logic [SW-1:0]   new_scale_c;
  logic            scale_chg_c;

  // Three-flop strobe synchroniser; one event per rising edge of the strobe
  always_ff @(posedge i_clock or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_data_received;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign event_c = s2_q & ~s3_q;

  // Next value of the frame-gap counter: cleared by an event, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (event_c) begin
      cnt_d = '0;
    end else if (cnt_q != TIMEOUT_CYCLES) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Frame-gap counter and stale flag, both updated on the event edge
  always_ff @(posedge i_clock or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q   <= '0;
      o_stale <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      o_stale <= !event_c && (cnt_d == TIMEOUT_CYCLES);
    end
  end

  // EMA step, filtered value, hysteresis distance and scale extraction
  always_comb begin
    acc_next_c  = acc_q - (acc_q >> SMOOTH_SHIFT) + AW'(samp_q);
    filt_c      = DW'(acc_q >> SMOOTH_SHIFT);
    if (filt_c >= o_frequency) begin
      diff_c = {1'b0, filt_c} - {1'b0, o_frequency};
    end else begin
      diff_c = {1'b0, o_frequency} - {1'b0, filt_c};
    end
    freq_load_c = !published_q || (diff_c >= {1'b0, HYSTERESIS});
    freq_chg_c  = freq_load_c && (filt_c != o_frequency);
    new_scale_c = SW'(raw_scale_q >> SCALE_SHIFT);
    scale_chg_c = ({1'b0, new_scale_c} != o_harmonic_scale);
  end

  // Frame sequencer: latch, filter, compare/publish, drop the update pulse
  always_ff @(posedge i_clock or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q          <= IDLE;
      pending_q        <= 1'b0;
      primed_q         <= 1'b0;
      published_q      <= 1'b0;
      samp_q           <= '0;
      raw_scale_q      <= '0;
      acc_q            <= '0;
      o_frequency      <= RESET_FREQ;
      o_harmonic_scale <= '0;
      o_update         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (event_c || pending_q) begin
            samp_q      <= i_data0;
            raw_scale_q <= i_data1;
            pending_q   <= 1'b0;
            state_q     <= FILTER;
          end
        end
        FILTER: begin
          if (event_c) begin
            pending_q <= 1'b1;
          end
          if (!primed_q) begin
            acc_q    <= AW'(samp_q) << SMOOTH_SHIFT;
            primed_q <= 1'b1;
          end else begin
            acc_q <= acc_next_c;
          end
          state_q <= COMPARE;
        end
        COMPARE: begin
          if (event_c) begin
            pending_q <= 1'b1;
          end
          if (freq_load_c) begin
            o_frequency <= filt_c;
          end
          if (scale_chg_c) begin
            o_harmonic_scale <= {1'b0, new_scale_c};
          end
          published_q <= 1'b1;
          o_update    <= freq_chg_c || scale_chg_c;
          state_q     <= PUBLISH;
        end
        PUBLISH: begin
          if (event_c) begin
            pending_q <= 1'b1;
          end
          o_update <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_control_conditioner.sv
// Directed bench for adc_control_conditioner with hand-computed expectations.
module tb_adc_control_conditioner;

  logic        clk;
  logic        rst_n;
  logic        strobe;
  logic [15:0] d0;
  logic [15:0] d1;
  logic [15:0] freq;
  logic [5:0]  scale;
  logic        upd;
  logic        stale;

  int errors = 0;
  int checks = 0;
  int upd_count;

  adc_control_conditioner #(
    .SMOOTH_SHIFT  (3),
    .HYSTERESIS    (16'd4),
    .SCALE_SHIFT   (11),
    .RESET_FREQ    (16'd1000),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .i_clock         (clk),
    .i_rstn          (rst_n),
    .i_data_received (strobe),
    .i_data0         (d0),
    .i_data1         (d1),
    .o_frequency     (freq),
    .o_harmonic_scale(scale),
    .o_update        (upd),
    .o_stale         (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; checks the pulse timing k+4/k+5 and the published values
  task automatic run_frame(input string tag, input logic [15:0] f0, input logic [15:0] f1,
                           input logic [15:0] exp_f, input logic [5:0] exp_s, input logic exp_u);
    d0 = f0;
    d1 = f1;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    tick();
    tick();
    chk({tag, "_upd_k3"}, 32'(upd), 32'd0);
    tick();
    chk({tag, "_upd_k4"}, 32'(upd), 32'(exp_u));
    chk({tag, "_freq"}, 32'(freq), 32'(exp_f));
    chk({tag, "_scale"}, 32'(scale), 32'(exp_s));
    tick();
    chk({tag, "_upd_k5"}, 32'(upd), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    strobe = 1'b0;
    d0     = 16'd0;
    d1     = 16'd0;
    tick();
    tick();
    rst_n = 1'b1;

    // Idle after reset: reset values held until the timeout
    for (int i = 1; i <= 99; i++) begin
      tick();
      chk("idle_freq", 32'(freq), 32'd1000);
      chk("idle_scale", 32'(scale), 32'd0);
      chk("idle_upd", 32'(upd), 32'd0);
      chk("idle_stale", 32'(stale), 32'd0);
    end
    tick();
    chk("stale_rise", 32'(stale), 32'd1);

    // First frame: clears stale at the event edge, loads 2000 / scale 11
    d0 = 16'd2000;
    d1 = 16'h5800;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    chk("stale_k0", 32'(stale), 32'd1);
    tick();
    chk("stale_k1", 32'(stale), 32'd1);
    tick();
    chk("stale_k2", 32'(stale), 32'd0);
    tick();
    chk("f1_upd_k3", 32'(upd), 32'd0);
    chk("f1_freq_k3", 32'(freq), 32'd1000);
    tick();
    chk("f1_upd_k4", 32'(upd), 32'd1);
    chk("f1_freq", 32'(freq), 32'd2000);
    chk("f1_scale", 32'(scale), 32'd11);
    tick();
    chk("f1_upd_k5", 32'(upd), 32'd0);

    // Jitter suppressed (filt 2001, diff 1), then a real move to 2125
    run_frame("f2008", 16'd2008, 16'h5800, 16'd2000, 6'd11, 1'b0);
    run_frame("f3000", 16'd3000, 16'h5800, 16'd2125, 6'd11, 1'b1);

    // Held strobe: one event only; filt = 17882>>3 = 2235
    d0 = 16'd3000;
    strobe = 1'b1;
    upd_count = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (upd) upd_count++;
    end
    strobe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (upd) upd_count++;
    end
    chk("held_upd_count", 32'(upd_count), 32'd1);
    chk("held_freq", 32'(freq), 32'd2235);

    // Collision: second event while busy is held pending and run afterwards
    d0 = 16'd3000;
    d1 = 16'h0800;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    upd_count = 0;
    tick();
    strobe = 1'b1;
    chk("col_upd_k1", 32'(upd), 32'd0);
    tick();
    strobe = 1'b0;
    d1 = 16'h1000;
    chk("col_upd_k2", 32'(upd), 32'd0);
    for (int i = 3; i <= 12; i++) begin
      tick();
      if (upd) upd_count++;
      chk("col_upd", 32'(upd), ((i == 4) || (i == 8)) ? 32'd1 : 32'd0);
      if (i == 4) begin
        chk("col_a_freq", 32'(freq), 32'd2330);
        chk("col_a_scale", 32'(scale), 32'd1);
      end
      if (i == 8) begin
        chk("col_b_freq", 32'(freq), 32'd2414);
        chk("col_b_scale", 32'(scale), 32'd2);
      end
    end
    chk("col_upd_count", 32'(upd_count), 32'd2);

    // Reset asserted while the frame sits in COMPARE
    d0 = 16'd500;
    d1 = 16'd0;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_freq", 32'(freq), 32'd1000);
    chk("rst_scale", 32'(scale), 32'd0);
    chk("rst_upd", 32'(upd), 32'd0);
    chk("rst_stale", 32'(stale), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_upd", 32'(upd), 32'd0);
      chk("post_rst_freq", 32'(freq), 32'd1000);
    end

    // First frame after reset bypasses hysteresis (diff 2)
    run_frame("r1002", 16'd1002, 16'd0, 16'd1002, 6'd0, 1'b1);
    // diff exactly 4 loads; scale saturates the 5-bit field at 31
    run_frame("h4", 16'd1034, 16'hFFFF, 16'd1006, 6'd31, 1'b1);
    // diff 3 downward: held
    run_frame("h3", 16'd982, 16'hFFFF, 16'd1006, 6'd31, 1'b0);
    // scale-only change still pulses o_update
    run_frame("sc", 16'd1003, 16'h0000, 16'd1006, 6'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
